// File: rtl/disp_pkg.sv
// Shared definitions for the single-digit display control path:
// auto-repeat FSM encoding, digit width and the modulo step helpers.
package disp_pkg;

  localparam int DIGIT_W       = 4;
  localparam int MAX_DIGIT_DEF = 5;

  localparam logic [DIGIT_W-1:0] DIGIT_ZERO = DIGIT_W'(0);
  localparam logic [DIGIT_W-1:0] DIGIT_ONE  = DIGIT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // Up step; anything at or above the top folds back to zero so the value stays in range.
  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] max_d);
    logic [DIGIT_W-1:0] r;
    if (d >= max_d) begin
      r = DIGIT_ZERO;
    end else begin
      r = d + DIGIT_ONE;
    end
    return r;
  endfunction

  function automatic logic digit_inc_wraps(input logic [DIGIT_W-1:0] d,
                                           input logic [DIGIT_W-1:0] max_d);
    return (d >= max_d);
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_dec(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] max_d);
    logic [DIGIT_W-1:0] r;
    if ((d == DIGIT_ZERO) || (d > max_d)) begin
      r = max_d;
    end else begin
      r = d - DIGIT_ONE;
    end
    return r;
  endfunction

  function automatic logic digit_dec_wraps(input logic [DIGIT_W-1:0] d);
    return (d == DIGIT_ZERO);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-FF synchronizer, stable-cycle counter, debounced level
// and a registered one-cycle strobe that coincides with the level rising.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 200_000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;
  logic             rise_q;
  logic             rise_d;

  // Count cycles the synced input disagrees with the level; any agreement restarts the count.
  always_comb begin
    cnt_d  = CNT_ZERO;
    db_d   = db_q;
    rise_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = CNT_ZERO;
        db_d   = ~db_q;
        rise_d = ~db_q;
      end else begin
        cnt_d  = cnt_q + CNT_ONE;
        db_d   = db_q;
        rise_d = 1'b0;
      end
    end else begin
      cnt_d  = CNT_ZERO;
      db_d   = db_q;
      rise_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = db_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/btn_digit_ctrl.sv
// Turns debounced up/down/clear presses (with auto-repeat while held) into
// the modulo digit shown on the seven-segment display.
module btn_digit_ctrl
  import disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200_000,
  parameter int REPEAT_DELAY    = 10_000_000,
  parameter int REPEAT_RATE     = 4_000_000,
  parameter int MAX_DIGIT       = MAX_DIGIT_DEF,
  parameter int CNT_W           = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               step_pulse,
  output logic               wrap_pulse
);

  localparam logic [DIGIT_W-1:0] MAX_D      = DIGIT_W'(MAX_DIGIT);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0]   RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic db_up_s;
  logic db_down_s;
  logic db_clr_s;
  logic up_rise_s;
  logic down_rise_s;
  logic clr_rise_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_up),
    .level_o(db_up_s),
    .rise_o (up_rise_s)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_down),
    .level_o(db_down_s),
    .rise_o (down_rise_s)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_clr),
    .level_o(db_clr_s),
    .rise_o (clr_rise_s)
  );

  rpt_state_e         state_q;
  logic [CNT_W-1:0]   timer_q;
  logic [DIGIT_W-1:0] digit_q;
  logic               dir_up_q;
  logic               step_q;
  logic               wrap_q;

  logic               step_up_s;
  logic [DIGIT_W-1:0] step_val_s;
  logic               step_wrap_s;
  logic               act_held_s;
  logic               other_held_s;
  logic               period_done_s;

  // In IDLE the direction comes from the fresh edge; once repeating it is the latched button.
  always_comb begin
    step_up_s   = 1'b0;
    step_val_s  = digit_q;
    step_wrap_s = 1'b0;
    if (state_q == ST_IDLE) begin
      step_up_s = up_rise_s;
    end else begin
      step_up_s = dir_up_q;
    end
    if (step_up_s) begin
      step_val_s  = digit_inc(digit_q, MAX_D);
      step_wrap_s = digit_inc_wraps(digit_q, MAX_D);
    end else begin
      step_val_s  = digit_dec(digit_q, MAX_D);
      step_wrap_s = digit_dec_wraps(digit_q);
    end
  end

  always_comb begin
    act_held_s    = 1'b0;
    other_held_s  = 1'b0;
    period_done_s = 1'b0;
    if (dir_up_q) begin
      act_held_s   = db_up_s;
      other_held_s = db_down_s;
    end else begin
      act_held_s   = db_down_s;
      other_held_s = db_up_s;
    end
    if (state_q == ST_DELAY) begin
      period_done_s = (timer_q == DELAY_LAST);
    end else begin
      period_done_s = (timer_q == RATE_LAST);
    end
  end

  // Clear wins over everything; both direction buttons held together parks the FSM in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= CNT_ZERO;
      digit_q  <= DIGIT_ZERO;
      dir_up_q <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clr_rise_s) begin
        digit_q <= DIGIT_ZERO;
        step_q  <= 1'b1;
        state_q <= ST_IDLE;
        timer_q <= CNT_ZERO;
      end else if (db_clr_s || (db_up_s && db_down_s)) begin
        state_q <= ST_IDLE;
        timer_q <= CNT_ZERO;
      end else begin
        case (state_q)
          ST_IDLE: begin
            timer_q <= CNT_ZERO;
            if (up_rise_s || down_rise_s) begin
              digit_q  <= step_val_s;
              wrap_q   <= step_wrap_s;
              step_q   <= 1'b1;
              dir_up_q <= up_rise_s;
              state_q  <= ST_DELAY;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_DELAY, ST_REPEAT: begin
            if (!act_held_s || other_held_s) begin
              state_q <= ST_IDLE;
              timer_q <= CNT_ZERO;
            end else if (period_done_s) begin
              digit_q <= step_val_s;
              wrap_q  <= step_wrap_s;
              step_q  <= 1'b1;
              timer_q <= CNT_ZERO;
              state_q <= ST_REPEAT;
            end else begin
              timer_q <= timer_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            timer_q <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign digit      = digit_q;
  assign step_pulse = step_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_btn_digit_ctrl.sv
// Directed bench for btn_digit_ctrl: a per-cycle vector table for the basic press,
// then hand-written sequences for bounce, auto-repeat, wrap, clear priority and reset mid-hold.
module tb_btn_digit_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_up;
  logic       btn_down;
  logic       btn_clr;
  logic [3:0] digit;
  logic       step_pulse;
  logic       wrap_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         ev_cyc  [$];
  logic [3:0] ev_dig  [$];
  logic       ev_wrap [$];

  typedef struct {
    logic       rst_n;
    logic       up;
    logic [3:0] dig;
    logic       step;
    logic       wrap;
  } vec_t;

  vec_t tbl [22];

  int         t3_off [6] = '{7, 27, 35, 43, 51, 59};
  logic [3:0] t3_dig [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};

  btn_digit_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8),
    .MAX_DIGIT      (5),
    .CNT_W          (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_clr   (btn_clr),
    .digit     (digit),
    .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (step_pulse === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_dig.push_back(digit);
      ev_wrap.push_back(wrap_pulse);
    end
  endtask

  task automatic clear_ev();
    ev_cyc.delete();
    ev_dig.delete();
    ev_wrap.delete();
  endtask

  task automatic drive(input logic u, input logic d, input logic c);
    btn_up   = u;
    btn_down = d;
    btn_clr  = c;
  endtask

  task automatic check_out(input string name, input logic [3:0] ed, input logic es, input logic ew);
    total++;
    if (digit !== ed || step_pulse !== es || wrap_pulse !== ew) begin
      bad++;
      $display("FAIL %s: got digit=%0d step=%0b wrap=%0b, want digit=%0d step=%0b wrap=%0b",
               name, digit, step_pulse, wrap_pulse, ed, es, ew);
    end
  endtask

  task automatic check_cnt(input string name, input int n);
    total++;
    if (ev_cyc.size() != n) begin
      bad++;
      $display("FAIL %s: got %0d steps, want %0d", name, ev_cyc.size(), n);
    end
  endtask

  task automatic check_ev(input string name, input int idx, input int ec, input logic [3:0] ed,
                          input logic ew);
    total++;
    if (idx >= ev_cyc.size()) begin
      bad++;
      $display("FAIL %s: step %0d missing, want cycle=%0d digit=%0d wrap=%0b", name, idx, ec, ed, ew);
    end else if (ev_cyc[idx] != ec || ev_dig[idx] !== ed || ev_wrap[idx] !== ew) begin
      bad++;
      $display("FAIL %s: got cycle=%0d digit=%0d wrap=%0b, want cycle=%0d digit=%0d wrap=%0b",
               name, ev_cyc[idx], ev_dig[idx], ev_wrap[idx], ec, ed, ew);
    end
  endtask

  // Press one button for 10 cycles, release for 10; exactly one step 7 edges after the press.
  task automatic press_one(input string name, input logic u, input logic d, input logic c,
                           input logic [3:0] ed, input logic ew);
    int base;
    clear_ev();
    base = cyc;
    drive(u, d, c);
    repeat (10) tick();
    drive(1'b0, 1'b0, 1'b0);
    repeat (10) tick();
    check_cnt({name, "_count"}, 1);
    check_ev(name, 0, base + 7, ed, ew);
  endtask

  initial begin
    int base;
    int rbase;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // {rst_n, up, digit, step, wrap} after each edge
    tbl[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0};

    for (int i = 0; i < 22; i++) begin
      rst_n  = tbl[i].rst_n;
      btn_up = tbl[i].up;
      tick();
      check_out($sformatf("t1_vec%0d", i), tbl[i].dig, tbl[i].step, tbl[i].wrap);
    end

    // Bounce 1,0,1,0 in 2-cycle chunks, then a stable press: one step timed from the last rise.
    clear_ev();
    btn_up = 1'b1; tick(); tick();
    btn_up = 1'b0; tick(); tick();
    btn_up = 1'b1; tick(); tick();
    btn_up = 1'b0; tick(); tick();
    base = cyc;
    btn_up = 1'b1;
    repeat (12) tick();
    btn_up = 1'b0;
    repeat (12) tick();
    check_cnt("t2_count", 1);
    check_ev("t2_step", 0, base + 7, 4'd2, 1'b0);

    press_one("clr_from2", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);

    // Long hold: first step, delay, then repeat-rate steps through the MAX->0 wrap.
    clear_ev();
    base = cyc;
    btn_up = 1'b1;
    repeat (56) tick();
    btn_up = 1'b0;
    repeat (24) tick();
    check_cnt("t3_count", 6);
    for (int i = 0; i < 6; i++) begin
      check_ev($sformatf("t3_step%0d", i), i, base + t3_off[i], t3_dig[i], (i == 5));
    end
    check_out("t3_final", 4'd0, 1'b0, 1'b0);

    // Down from 0 wraps to MAX; both buttons together never step, nor does releasing one.
    press_one("t4_down", 1'b0, 1'b1, 1'b0, 4'd5, 1'b1);
    clear_ev();
    drive(1'b1, 1'b1, 1'b0);
    repeat (30) tick();
    btn_down = 1'b0;
    repeat (15) tick();
    btn_up = 1'b0;
    repeat (10) tick();
    check_cnt("t4_both", 0);
    check_out("t4_hold", 4'd5, 1'b0, 1'b0);

    // Clear lands on the same edge a repeat step is due at digit 3; clear must win.
    press_one("t5_clr", 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    clear_ev();
    base = cyc;
    btn_up = 1'b1;
    repeat (36) tick();
    btn_clr = 1'b1;
    repeat (14) tick();
    btn_clr = 1'b0;
    repeat (40) tick();
    btn_up = 1'b0;
    repeat (10) tick();
    check_cnt("t5_count", 4);
    check_ev("t5_s0", 0, base + 7, 4'd1, 1'b0);
    check_ev("t5_s1", 1, base + 27, 4'd2, 1'b0);
    check_ev("t5_s2", 2, base + 35, 4'd3, 1'b0);
    check_ev("t5_clr_step", 3, base + 43, 4'd0, 1'b0);
    press_one("t5_repress", 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    press_one("t5_up2", 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);

    // Reset for one cycle mid-DELAY with down held: down must re-debounce before stepping.
    clear_ev();
    base = cyc;
    btn_down = 1'b1;
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    check_out("t6_reset", 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    rbase = cyc;
    repeat (12) tick();
    btn_down = 1'b0;
    repeat (12) tick();
    check_cnt("t6_count", 2);
    check_ev("t6_pre", 0, base + 7, 4'd1, 1'b0);
    check_ev("t6_post", 1, rbase + 7, 4'd5, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
